// File: rtl/bp_ctrl_pkg.sv
// Shared types for the branch-predictor table controller: FSM states and the
// update FIFO entry.
package bp_ctrl_pkg;

    // Entry fields are sized to the widest supported configuration; users
    // zero-extend into the entry and slice back out.
    localparam int unsigned BP_MAX_IDX_W = 16;
    localparam int unsigned BP_MAX_UPD_W = 128;

    typedef enum logic {
        SWEEP,
        RUN
    } bp_sched_state_e;

    typedef struct packed {
        logic [BP_MAX_IDX_W-1:0] index;
        logic [BP_MAX_UPD_W-1:0] data;
    } bp_upd_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO, port-compatible with common-cells fifo_v3 (non-fall-through).
// Flush empties the FIFO and suppresses any push/pop in the same cycle.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    dtype                  mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_update_sched.sv
// Branch-predictor table write scheduler: clear sweep after reset/flush, then
// drains resolved-branch updates from a FIFO onto the single table write port.
module bp_update_sched
    import bp_ctrl_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned UPD_W      = 64,
    localparam int unsigned IDX_W     = $clog2(NR_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_bp_i,
    input  logic             debug_mode_i,
    input  logic             upd_valid_i,
    output logic             upd_ready_o,
    input  logic [UPD_W-1:0] upd_data_i,
    input  logic [IDX_W-1:0] upd_index_i,
    output logic             tbl_we_o,
    input  logic             tbl_ready_i,
    output logic             tbl_clr_o,
    output logic [IDX_W-1:0] tbl_index_o,
    output logic [UPD_W-1:0] tbl_data_o,
    output logic             pred_block_o,
    output logic             busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

    if (IDX_W > BP_MAX_IDX_W || UPD_W > BP_MAX_UPD_W) begin : g_width_check
        $error("bp_update_sched: IDX_W/UPD_W exceed bp_upd_entry_t field widths");
    end

    bp_sched_state_e  state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             clr_q, clr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [UPD_W-1:0] data_q, data_d;
    logic             pblk_q, pblk_d;

    logic             load_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    bp_upd_entry_t    fifo_in;
    bp_upd_entry_t    fifo_out;

    logic [$clog2(FIFO_DEPTH)-1:0] unused_usage;
    logic                          unused_hi;

    assign load_en     = !we_q || tbl_ready_i;
    assign upd_ready_o = (state_q == RUN) && !fifo_full && !flush_bp_i;
    // Debug-mode updates still handshake but never reach the FIFO.
    assign push        = upd_valid_i && upd_ready_o && !debug_mode_i;

    assign fifo_in.index = BP_MAX_IDX_W'(upd_index_i);
    assign fifo_in.data  = BP_MAX_UPD_W'(upd_data_i);
    assign unused_hi     = ^{fifo_out.index >> IDX_W, fifo_out.data >> UPD_W};

    fifo_v3 #(
        .DEPTH (FIFO_DEPTH),
        .dtype (bp_upd_entry_t)
    ) i_upd_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_bp_i),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (unused_usage),
        .data_i     (fifo_in),
        .push_i     (push),
        .data_o     (fifo_out),
        .pop_i      (pop)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        clr_d   = clr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pblk_d  = pblk_q;
        pop     = 1'b0;

        if (we_q && tbl_ready_i && clr_q && (idx_q == LAST_IDX)) begin
            pblk_d = 1'b0;
        end

        if (flush_bp_i) begin
            state_d = SWEEP;
            cnt_d   = '0;
            we_d    = 1'b0;
            clr_d   = 1'b0;
            idx_d   = '0;
            data_d  = '0;
            pblk_d  = 1'b1;
        end else begin
            unique case (state_q)
                SWEEP: begin
                    if (load_en) begin
                        we_d   = 1'b1;
                        clr_d  = 1'b1;
                        idx_d  = cnt_q;
                        data_d = '0;
                        if (cnt_q == LAST_IDX) begin
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load_en) begin
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            we_d   = 1'b1;
                            clr_d  = 1'b0;
                            idx_d  = fifo_out.index[IDX_W-1:0];
                            data_d = fifo_out.data[UPD_W-1:0];
                        end else begin
                            we_d = 1'b0;
                        end
                    end
                end
                default: state_d = SWEEP;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            clr_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            pblk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            clr_q   <= clr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pblk_q  <= pblk_d;
        end
    end

    assign tbl_we_o     = we_q;
    assign tbl_clr_o    = clr_q;
    assign tbl_index_o  = idx_q;
    assign tbl_data_o   = data_q;
    assign pred_block_o = pblk_q;
    assign busy_o       = (state_q == SWEEP) || !fifo_empty || we_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched with an 8-entry table and 4-deep FIFO.
module tb_bp_update_sched;

    localparam int unsigned NR = 8;
    localparam int unsigned FD = 4;
    localparam int unsigned UW = 64;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          dbg = 1'b0;
    logic          uv = 1'b0;
    logic          ur;
    logic [UW-1:0] ud = '0;
    logic [IW-1:0] ui = '0;
    logic          we;
    logic          tr = 1'b1;
    logic          clr;
    logic [IW-1:0] ti;
    logic [UW-1:0] td;
    logic          pblk;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_update_sched #(
        .NR_ENTRIES (NR),
        .FIFO_DEPTH (FD),
        .UPD_W      (UW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_bp_i   (flush),
        .debug_mode_i (dbg),
        .upd_valid_i  (uv),
        .upd_ready_o  (ur),
        .upd_data_i   (ud),
        .upd_index_i  (ui),
        .tbl_we_o     (we),
        .tbl_ready_i  (tr),
        .tbl_clr_o    (clr),
        .tbl_index_o  (ti),
        .tbl_data_o   (td),
        .pred_block_o (pblk),
        .busy_o       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tr = 1'b1;
        #12;
        checks++;
        if ({we, clr, ti, td, pblk, busy, ur} !== {1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", {we, clr, ti, td, pblk, busy, ur},
                     {1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({we, clr, ti, td, pblk, ur} !== {2'b11, 3'(k), 64'h0, 1'b1, (k == 7)}) begin
                errors++;
                $display("FAIL reset_sweep_clear%0d: got %h expected %h", k, {we, clr, ti, td, pblk, ur},
                         {2'b11, 3'(k), 64'h0, 1'b1, (k == 7)});
            end
        end
        step();
        checks++;
        if ({we, pblk, busy, ur} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_sweep_end: got %b expected 0001", {we, pblk, busy, ur});
        end
    endtask

    task automatic test_single_update();
        step();
        uv = 1'b1;
        ud = 64'hA5;
        ui = 3'd3;
        #1;
        checks++;
        if (ur !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", ur);
        end
        step();
        uv = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL single_c1_idle: got we=%b expected 0", we);
        end
        step();
        checks++;
        if ({we, clr, ti, td} !== {2'b10, 3'd3, 64'hA5}) begin
            errors++;
            $display("FAIL single_c2_write: got %h expected %h", {we, clr, ti, td}, {2'b10, 3'd3, 64'hA5});
        end
        step();
        checks++;
        if ({we, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_done: got %b expected 00", {we, busy});
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] bd [6];
        logic [2:0]  bi [6];
        bd = '{64'h1111_0001, 64'h2222_0002, 64'h3333_0003, 64'h4444_0004, 64'h5555_0005, 64'h6666_0006};
        bi = '{3'd1, 3'd6, 3'd2, 3'd7, 3'd0, 3'd5};
        step();
        tr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            uv = 1'b1;
            ud = bd[i];
            ui = bi[i];
            #1;
            checks++;
            if (ur !== (i < 5)) begin
                errors++;
                $display("FAIL bp_ready%0d: got %b expected %b", i, ur, (i < 5));
            end
            step();
        end
        uv = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if ({we, clr, ti, td, busy} !== {2'b10, bi[0], bd[0], 1'b1}) begin
                errors++;
                $display("FAIL bp_stall_hold%0d: got %h expected %h", s, {we, clr, ti, td, busy},
                         {2'b10, bi[0], bd[0], 1'b1});
            end
            step();
        end
        tr = 1'b1;
        uv = 1'b1;
        ud = 64'hDEAD;
        ui = 3'd4;
        #1;
        checks++;
        if (ur !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_with_pop: got ready=%b expected 0", ur);
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if ({we, clr, ti, td} !== {2'b10, bi[j], bd[j]}) begin
                errors++;
                $display("FAIL bp_drain%0d: got %h expected %h", j, {we, clr, ti, td}, {2'b10, bi[j], bd[j]});
            end
            step();
            uv = 1'b0;
            #1;
        end
        checks++;
        if ({we, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bp_drained: got %b expected 00", {we, busy});
        end
    endtask

    task automatic test_flush_run();
        step();
        tr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            uv = 1'b1;
            ud = 64'hF000 + 64'(i);
            ui = 3'(i + 2);
            #1;
            checks++;
            if (ur !== 1'b1) begin
                errors++;
                $display("FAIL flush_fill_ready%0d: got %b expected 1", i, ur);
            end
            step();
        end
        flush = 1'b1;
        uv = 1'b1;
        ud = 64'h77;
        ui = 3'd2;
        #1;
        checks++;
        if ({ur, busy} !== 2'b01) begin
            errors++;
            $display("FAIL flush_cycle_ready: got %b expected 01", {ur, busy});
        end
        step();
        flush = 1'b0;
        uv = 1'b0;
        tr = 1'b1;
        #1;
        checks++;
        if ({we, pblk, busy} !== 3'b011) begin
            errors++;
            $display("FAIL flush_discard: got %b expected 011", {we, pblk, busy});
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({we, clr, ti, td, pblk} !== {2'b11, 3'(k), 64'h0, 1'b1}) begin
                errors++;
                $display("FAIL flush_sweep%0d: got %h expected %h", k, {we, clr, ti, td, pblk},
                         {2'b11, 3'(k), 64'h0, 1'b1});
            end
        end
        step();
        checks++;
        if ({we, pblk, busy} !== 3'b000) begin
            errors++;
            $display("FAIL flush_end: got %b expected 000", {we, pblk, busy});
        end
    endtask

    task automatic test_debug();
        step();
        dbg = 1'b1;
        for (int i = 0; i < 2; i++) begin
            uv = 1'b1;
            ud = 64'hD0 + 64'(i);
            ui = 3'(i + 1);
            #1;
            checks++;
            if (ur !== 1'b1) begin
                errors++;
                $display("FAIL debug_ready%0d: got %b expected 1", i, ur);
            end
            step();
        end
        uv = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            checks++;
            if ({we, busy} !== 2'b00) begin
                errors++;
                $display("FAIL debug_no_write%0d: got %b expected 00", s, {we, busy});
            end
            step();
        end
        dbg = 1'b0;
    endtask

    task automatic test_stalled_sweep();
        int   exp_idx;
        int   n;
        logic tog;
        step();
        flush = 1'b1;
        tr = 1'b0;
        step();
        flush = 1'b0;
        #1;
        checks++;
        if ({we, pblk} !== 2'b01) begin
            errors++;
            $display("FAIL stall_after_flush: got %b expected 01", {we, pblk});
        end
        exp_idx = 0;
        n = 0;
        tog = 1'b0;
        while (exp_idx != 5 && n < 40) begin
            step();
            tr = tog;
            tog = !tog;
            #1;
            checks++;
            if ({we, clr, ti, pblk} !== {2'b11, 3'(exp_idx), 1'b1}) begin
                errors++;
                $display("FAIL stall_sweep_n%0d: got %b expected %b", n, {we, clr, ti, pblk},
                         {2'b11, 3'(exp_idx), 1'b1});
            end
            if (tr) exp_idx++;
            n++;
        end
        checks++;
        if (exp_idx != 5) begin
            errors++;
            $display("FAIL stall_budget: got index %0d expected 5", exp_idx);
        end
        step();
        tr = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if ({we, clr, ti} !== {2'b11, 3'd5}) begin
            errors++;
            $display("FAIL stall_idx5: got %b expected %b", {we, clr, ti}, {2'b11, 3'd5});
        end
        step();
        checks++;
        if ({we, pblk} !== 2'b01) begin
            errors++;
            $display("FAIL stall_flush1: got %b expected 01", {we, pblk});
        end
        step();
        flush = 1'b0;
        tr = 1'b1;
        #1;
        checks++;
        if ({we, pblk} !== 2'b01) begin
            errors++;
            $display("FAIL stall_flush2: got %b expected 01", {we, pblk});
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({we, clr, ti, pblk} !== {2'b11, 3'(k), 1'b1}) begin
                errors++;
                $display("FAIL stall_resweep%0d: got %b expected %b", k, {we, clr, ti, pblk},
                         {2'b11, 3'(k), 1'b1});
            end
        end
        step();
        checks++;
        if ({we, pblk, busy} !== 3'b000) begin
            errors++;
            $display("FAIL stall_end: got %b expected 000", {we, pblk, busy});
        end
    endtask

    task automatic test_reset_midop();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({we, clr, ti, td, pblk, busy, ur} !== {1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midop_reset: got %h expected %h", {we, clr, ti, td, pblk, busy, ur},
                     {1'b0, 1'b0, 3'd0, 64'd0, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({we, clr, ti} !== {2'b11, 3'd0}) begin
            errors++;
            $display("FAIL midop_restart: got %b expected %b", {we, clr, ti}, {2'b11, 3'd0});
        end
        for (int k = 1; k < 9; k++) step();
        checks++;
        if ({we, pblk, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midop_end: got %b expected 000", {we, pblk, busy});
        end
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_backpressure();
        test_flush_run();
        test_debug();
        test_stalled_sweep();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
